// File: rtl/recover_plain_broadcast.sv
// recover_plain_broadcast: Horner-evaluates Q(r), S(r) over GF(2^32) and recovers a = alpha ^ eps*Q(r), b = beta ^ S(r).
module recover_plain_broadcast #(
  parameter FIELD = "GF256",
  parameter PARAMETER_SET = "L1",
  parameter int M = (PARAMETER_SET == "L5") ? 480 : (PARAMETER_SET == "L3") ? 352 : 230,
  parameter int T = (PARAMETER_SET == "L5") ? 4 : 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_q,
  output logic [$clog2(M)-1:0]  o_q_addr,
  output logic                  o_q_rd,
  input  logic [7:0]            i_s,
  output logic [$clog2(M)-1:0]  o_s_addr,
  output logic                  o_s_rd,
  input  logic [T*32-1:0]       i_alpha,
  input  logic [T*32-1:0]       i_beta,
  input  logic [T*32-1:0]       i_r,
  input  logic [T*32-1:0]       i_eps,
  output logic [T*32-1:0]       o_a,
  output logic [T*32-1:0]       o_b,
  output logic                  o_done
);
  localparam int AW = $clog2(M);
  localparam bit FIELD_OK = FIELD == "GF256";
  // Tower field: GF(2^8) mod 0x11B, GF(2^16) with y^2 = y + 0x20, GF(2^32) with z^2 = z + 0x20*y.
  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [15:0] gf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] hh;
    hh = gf8_mul(a[15:8], b[15:8]);
    return {hh ^ gf8_mul(a[15:8], b[7:0]) ^ gf8_mul(a[7:0], b[15:8]),
            gf8_mul(a[7:0], b[7:0]) ^ gf8_mul(8'h20, hh)};
  endfunction
  function automatic logic [31:0] gf32_mul(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] hh;
    hh = gf16_mul(a[31:16], b[31:16]);
    return {hh ^ gf16_mul(a[31:16], b[15:0]) ^ gf16_mul(a[15:0], b[31:16]),
            gf16_mul(a[15:0], b[15:0]) ^ gf16_mul(16'h2000, hh)};
  endfunction
  typedef enum logic [1:0] {IDLE, FETCH, FINAL, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic rd_q, rd_d, vld_q, vld_d;
  logic [T-1:0][31:0] alpha_q, alpha_d, beta_q, beta_d, r_q, r_d, eps_q, eps_d;
  logic [T-1:0][31:0] accq_q, accq_d, accs_q, accs_d, a_q, a_d, b_q, b_d;
  logic [T-1:0][31:0] hq, hs, ep;
  genvar j;
  for (j = 0; j < T; j++) begin : g_mul
    assign hq[j] = gf32_mul(accq_q[j], r_q[j]);
    assign hs[j] = gf32_mul(accs_q[j], r_q[j]);
    assign ep[j] = gf32_mul(eps_q[j], accq_q[j]);
  end
  always_comb begin
    state_d = state_q;
    addr_d = (rd_q && addr_q != '0) ? addr_q - AW'(1) : addr_q;
    rd_d = rd_q && addr_q != '0;
    vld_d = rd_q;
    alpha_d = alpha_q;
    beta_d = beta_q;
    r_d = r_q;
    eps_d = eps_q;
    accq_d = accq_q;
    accs_d = accs_q;
    a_d = a_q;
    b_d = b_q;
    // A byte returns the cycle after its strobe, so accumulation follows vld_q.
    if (vld_q) begin
      for (int k = 0; k < T; k++) begin
        accq_d[k] = hq[k] ^ {24'h0, i_q};
        accs_d[k] = hs[k] ^ {24'h0, i_s};
      end
    end
    case (state_q)
      IDLE: if (i_start && FIELD_OK) begin
        state_d = FETCH;
        addr_d = AW'(M - 1);
        rd_d = 1'b1;
        accq_d = '0;
        accs_d = '0;
        alpha_d = i_alpha;
        beta_d = i_beta;
        r_d = i_r;
        eps_d = i_eps;
      end
      FETCH: state_d = (vld_q && !rd_q) ? FINAL : FETCH;
      FINAL: begin
        a_d = alpha_q ^ ep;
        b_d = beta_q ^ accs_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      rd_q <= 1'b0;
      vld_q <= 1'b0;
      alpha_q <= '0;
      beta_q <= '0;
      r_q <= '0;
      eps_q <= '0;
      accq_q <= '0;
      accs_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rd_q <= rd_d;
      vld_q <= vld_d;
      alpha_q <= alpha_d;
      beta_q <= beta_d;
      r_q <= r_d;
      eps_q <= eps_d;
      accq_q <= accq_d;
      accs_q <= accs_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign o_q_addr = addr_q;
  assign o_s_addr = addr_q;
  assign o_q_rd = rd_q;
  assign o_s_rd = rd_q;
  assign o_a = a_q;
  assign o_b = b_q;
  assign o_done = state_q == DONE;
endmodule

// File: tb/tb_recover_plain_broadcast.sv
// tb_recover_plain_broadcast: directed vector table plus reset/restart sequences for recover_plain_broadcast (L1).
module tb_recover_plain_broadcast;
  localparam int M = 230;
  localparam int T = 3;
  localparam int AW = $clog2(M);
  typedef struct {
    bit fold;
    int qi;
    logic [7:0] qv;
    int si;
    logic [7:0] sv;
    logic [95:0] r, eps, alpha, beta, ea, eb;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] iq, is_;
  logic [AW-1:0] q_addr, s_addr;
  logic q_rd, s_rd, done;
  logic [95:0] alpha = '0, beta = '0, r = '0, eps = '0;
  logic [95:0] a, b;
  logic [7:0] qmem [M];
  logic [7:0] smem [M];
  logic log_clr = 1'b0;
  int nrd, bad;
  logic [AW-1:0] exp_addr;
  int nvec = 0, nerr = 0;
  vec_t tv [7];
  recover_plain_broadcast #(.FIELD("GF256"), .PARAMETER_SET("L1"), .M(M), .T(T)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_q(iq), .o_q_addr(q_addr), .o_q_rd(q_rd),
    .i_s(is_), .o_s_addr(s_addr), .o_s_rd(s_rd),
    .i_alpha(alpha), .i_beta(beta), .i_r(r), .i_eps(eps),
    .o_a(a), .o_b(b), .o_done(done)
  );
  always #5 clk = ~clk;
  // Coefficient memories with one-cycle read latency; also logs the address sequence.
  always @(posedge clk) begin
    iq <= q_rd ? qmem[q_addr] : 8'hee;
    is_ <= s_rd ? smem[s_addr] : 8'hee;
    if (log_clr) begin
      nrd <= 0;
      bad <= 0;
      exp_addr <= AW'(M - 1);
    end else if (q_rd || s_rd) begin
      nrd <= nrd + 1;
      if (!q_rd || !s_rd || q_addr != exp_addr || s_addr != exp_addr) bad <= bad + 1;
      exp_addr <= exp_addr - AW'(1);
    end
  end
  function automatic logic [7:0] pq(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction
  function automatic logic [7:0] ps(input int i);
    return 8'(((i * 91) ^ 92) & 255);
  endfunction
  task automatic chk(input string n, input logic [95:0] act, input logic [95:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic load(input vec_t v);
    for (int i = 0; i < M; i++) begin
      qmem[i] = v.fold ? pq(i) : (i == v.qi ? v.qv : 8'h00);
      smem[i] = v.fold ? ps(i) : (i == v.si ? v.sv : 8'h00);
    end
  endtask
  task automatic run(input vec_t v, input bit repulse, input string tag);
    int cyc;
    load(v);
    @(negedge clk);
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
    alpha = v.alpha;
    beta = v.beta;
    r = v.r;
    eps = v.eps;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    alpha = ~v.alpha;
    beta = ~v.beta;
    r = ~v.r;
    eps = ~v.eps;
    cyc = 1;
    while (!done && cyc < M + 50) begin
      @(negedge clk);
      cyc++;
      start = repulse && cyc == 10;
    end
    start = 1'b0;
    chk({tag, " latency"}, 96'(cyc), 96'(M + 3));
    chk({tag, " a"}, a, v.ea);
    chk({tag, " b"}, b, v.eb);
    chk({tag, " nreads"}, 96'(nrd), 96'(M));
    chk({tag, " addr_seq_errs"}, 96'(bad), 96'(0));
    @(negedge clk);
    chk({tag, " done_width"}, 96'(done), 96'(0));
    chk({tag, " a_hold"}, a, v.ea);
  endtask
  initial begin
    logic [7:0] fq, fs;
    logic [95:0] al, be, rr, ee, rsp, sq, one;
    int dcnt;
    fq = '0;
    fs = '0;
    for (int i = 0; i < M; i++) begin
      fq ^= pq(i);
      fs ^= ps(i);
    end
    al = 96'h711c27247a711d0abd8c81b3;
    be = 96'h53f9d79dbe40013312cd10f5;
    rr = 96'h01ac0e4b72e51961d2bb6fe5;
    ee = 96'h4562e7cb2e57ace77b41949f;
    one = {3{32'h1}};
    rsp = {32'h00010000, 32'h00000100, 32'h00000002};
    sq = {32'h00012000, 32'h00000120, 32'h00000004};
    tv[0] = '{0, 0, 8'h00, 0, 8'h00, rr, ee, al, be, al, be};
    tv[1] = '{0, 0, 8'h05, 0, 8'h0a, '0, one, 96'h0123456789abcdef00112233, 96'hdeadbeefcafef00d12345678,
              96'h0123456789abcdef00112233 ^ {3{32'h5}}, 96'hdeadbeefcafef00d12345678 ^ {3{32'ha}}};
    tv[2] = '{1, 0, 8'h00, 0, 8'h00, one, one, al, be, al ^ {3{24'h0, fq}}, be ^ {3{24'h0, fs}}};
    tv[3] = '{0, 0, 8'h01, 0, 8'h33, rr, ee, be, al, be ^ ee, al ^ {3{32'h33}}};
    tv[4] = '{0, 1, 8'h01, 1, 8'h01, rr, one, al, be, al ^ rr, be ^ rr};
    tv[5] = '{0, 2, 8'h01, 2, 8'h01, rsp, one, al, be, al ^ sq, be ^ sq};
    tv[6] = '{0, 1, 8'h01, 0, 8'h00, rsp, rsp, be, al, be ^ sq, al};
    repeat (3) @(negedge clk);
    chk("reset rd", 96'({q_rd, s_rd}), 96'(0));
    chk("reset addr", 96'({q_addr, s_addr}), 96'(0));
    chk("reset done", 96'(done), 96'(0));
    chk("reset ab", a | b, '0);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) run(tv[k], 1'b0, $sformatf("v%0d", k));
    run(tv[3], 1'b1, "restart_ignored");
    // Reset at cycle 50 aborts the operation.
    load(tv[1]);
    alpha = tv[1].alpha;
    beta = tv[1].beta;
    r = tv[1].r;
    eps = tv[1].eps;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    chk("mid rd_active", 96'(q_rd), 96'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort rd", 96'({q_rd, s_rd}), 96'(0));
    chk("abort done", 96'(done), 96'(0));
    chk("abort ab", a | b, '0);
    dcnt = 0;
    repeat (M + 20) begin
      @(negedge clk);
      if (done || q_rd) dcnt++;
    end
    chk("abort quiet", 96'(dcnt), 96'(0));
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("rst_wins rd", 96'(q_rd), 96'(0));
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_wins idle", 96'(q_rd), 96'(0));
    run(tv[2], 1'b0, "after_reset");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
